ray_core_dispatcher: RTL and testbench
======================================

RAY_CORE_DISPATCHER -- requirements
Module: ray_core_dispatcher

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of attached ray cores (1..8).
REQ-002 SHALL have parameter SCREEN_W, default 320, pixels per line.
REQ-003 SHALL have parameter SCREEN_H, default 240, lines per frame.
REQ-004 SHALL have parameter COORD_W, default 10, coordinate width.
REQ-005 SHALL have port clk  in  1  single clock, rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port frame_start  in  1  one-cycle request to render a frame.
REQ-008 SHALL have port busy  out  1  frame in progress.
REQ-009 SHALL have port frame_done  out  1  one-cycle pulse after the last pixel is accepted by the framebuffer.
REQ-010 SHALL have port core_strobe  out  NUM_CORES  one-hot start pulse to a core.
REQ-011 SHALL have ports core_x, core_y  out  COORD_W each  pixel for the strobed core, valid with core_strobe.
REQ-012 SHALL have port core_done  in  NUM_CORES  one-cycle per-core result pulse.
REQ-013 SHALL have port core_color  in  NUM_CORES*24  per-core RGB888, valid with core_done.
REQ-014 SHALL have ports fb_valid out 1, fb_ready in 1, fb_x/fb_y out COORD_W, fb_color out 24  framebuffer write handshake.

Function
REQ-015 SHALL implement FSM IDLE -> DISPATCH (frame_start) -> DRAIN (last pixel issued) -> DONE (all slots empty, none in flight) -> IDLE, one cycle in DONE.
REQ-016 SHALL ignore frame_start outside IDLE.
REQ-017 SHALL keep per-core state FREE / BUSY / RESULT plus latched x,y and color.
REQ-018 SHALL in DISPATCH strobe at most one FREE core per cycle, chosen round-robin starting after the last granted index; that core becomes BUSY.
REQ-019 SHALL issue pixels raster order: x 0..SCREEN_W-1, then y+1, x wraps to 0; last pixel (SCREEN_W-1, SCREEN_H-1) moves FSM to DRAIN same cycle.
REQ-020 SHALL on core_done for a BUSY core latch color, set RESULT; core_done on a non-BUSY core is ignored.
REQ-021 SHALL select RESULT slots round-robin into one output register; fb_* stable while fb_valid=1 and fb_ready=0.
REQ-022 SHALL on fb_valid&fb_ready free that slot (FREE next cycle) and may load the next result the same cycle (full throughput 1 pixel/cycle).
REQ-023 SHALL not re-strobe a core until its slot is FREE; a slot freed in cycle N is strobable in N+1.
REQ-024 SHALL keep busy=1 from the cycle after accepted frame_start through the DONE cycle; frame_done=1 only in DONE.

Reset
REQ-025 SHALL on reset: FSM IDLE, all slots FREE, counters 0, round-robin pointers 0, core_strobe=0, fb_valid=0, busy=0, frame_done=0, fb_x/fb_y/fb_color=0.
REQ-026 SHALL on reset mid-frame abandon all work; core_done pulses after reset deassertion are ignored (slots FREE).

Configuration
REQ-027 SHALL with macro RAY_DISPATCH_PERF_EN add outputs perf_cycles (32) counting cycles with busy=1 and perf_stall (32) counting DISPATCH cycles with no FREE core, both cleared on accepted frame_start and held after DONE.
REQ-028 SHALL without RAY_DISPATCH_PERF_EN omit those ports and counters entirely.

Structure
REQ-029 SHALL place slot-state enum, FSM state enum and color width constant in the shared renderer package.
REQ-030 SHALL implement the rotating priority picker as sub-module rr_arbiter (request vector, pointer -> one-hot grant), instantiated for dispatch and for collection.

Verification
REQ-031 SHALL cover: SCREEN_W=4, SCREEN_H=2, cores answer 3 cycles after strobe, fb_ready=1 -> 8 fb writes covering all (x,y), frame_done once, busy low afterwards.
REQ-032 SHALL cover: fb_ready held 0 for 20 cycles -> fb_* constant, no core strobed beyond NUM_CORES outstanding, no pixel lost.
REQ-033 SHALL cover: all 4 cores done same cycle -> 4 consecutive fb writes in round-robin order from collection pointer.
REQ-034 SHALL cover: frame_start during DISPATCH -> ignored, pixel count still SCREEN_W*SCREEN_H.
REQ-035 SHALL cover: reset asserted mid-frame, stale core_done afterwards -> outputs at reset values, no fb_valid.
REQ-036 SHALL cover: with RAY_DISPATCH_PERF_EN, single core, 3-cycle latency, 4x2 frame -> perf_stall nonzero, perf_cycles equals measured busy duration.

Source files
------------

// File: rtl/ray_core_dispatcher_pkg.sv
// Shared renderer package for the ray core dispatcher.
// Holds the per-core slot state encoding, the dispatcher FSM state encoding
// and the RGB888 colour width used on the core and framebuffer interfaces.
package ray_core_dispatcher_pkg;

  localparam int COLOR_W = 24;

  typedef enum logic [1:0] {
    SLOT_FREE   = 2'd0,
    SLOT_BUSY   = 2'd1,
    SLOT_RESULT = 2'd2
  } slot_state_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_DONE     = 2'd3
  } disp_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority picker.
// Ports:
//   req       - request vector, one bit per requester
//   ptr       - index searched first; the search wraps upward from here
//   grant     - one-hot grant (all zero when no request)
//   grant_idx - binary index of the granted requester
//   any       - at least one request was granted
module rr_arbiter
  import ray_core_dispatcher_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any
);

  always_comb begin
    int unsigned j;
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr) + k) % N;
      if (!any && req[j]) begin
        grant[j]  = 1'b1;
        grant_idx = PTR_W'(j);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ray_core_dispatcher.sv
// Ray core dispatcher: walks a frame in raster order, hands one pixel per
// cycle to a free ray core, collects per-core results and streams them to the
// framebuffer through a valid/ready register.
// Optional feature macro: RAY_DISPATCH_PERF_EN (adds perf_cycles/perf_stall).
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   frame_start           - one-cycle frame request (honoured only in IDLE)
//   busy, frame_done      - frame in progress / one-cycle completion pulse
//   core_strobe/x/y       - one-hot core start pulse with the pixel coordinate
//   core_done/core_color  - per-core result pulse with RGB888 colour
//   fb_valid/ready/x/y/color - framebuffer write handshake
//   perf_cycles/perf_stall   - (macro only) busy cycles / dispatch stalls
module ray_core_dispatcher
  import ray_core_dispatcher_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int SCREEN_W  = 320,
  parameter int SCREEN_H  = 240,
  parameter int COORD_W   = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_start,
  output logic                         busy,
  output logic                         frame_done,
  output logic [NUM_CORES-1:0]         core_strobe,
  output logic [COORD_W-1:0]           core_x,
  output logic [COORD_W-1:0]           core_y,
  input  logic [NUM_CORES-1:0]         core_done,
  input  logic [NUM_CORES*COLOR_W-1:0] core_color,
  output logic                         fb_valid,
  input  logic                         fb_ready,
  output logic [COORD_W-1:0]           fb_x,
  output logic [COORD_W-1:0]           fb_y,
  output logic [COLOR_W-1:0]           fb_color
`ifdef RAY_DISPATCH_PERF_EN
  ,
  output logic [31:0]                  perf_cycles,
  output logic [31:0]                  perf_stall
`endif
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [PTR_W-1:0]   LAST_IDX = PTR_W'(NUM_CORES - 1);
  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(SCREEN_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(SCREEN_H - 1);

  disp_state_t        state;
  slot_state_t        slot_state [NUM_CORES];
  logic [COORD_W-1:0] slot_x     [NUM_CORES];
  logic [COORD_W-1:0] slot_y     [NUM_CORES];
  logic [COLOR_W-1:0] slot_color [NUM_CORES];

  logic [COORD_W-1:0] x_cnt, y_cnt;
  logic [PTR_W-1:0]   disp_ptr, coll_ptr, fb_slot;

  logic [NUM_CORES-1:0] free_vec, result_vec, dispatch_req;
  logic [NUM_CORES-1:0] disp_grant, coll_grant;
  logic [PTR_W-1:0]     disp_idx, coll_idx;
  logic                 disp_any, coll_any;
  logic                 fb_accept, fb_load_ok;
  logic [COORD_W-1:0]   coll_x, coll_y;
  logic [COLOR_W-1:0]   coll_color;

  // The slot currently sitting in the output register stays RESULT until it
  // is accepted, so it is masked out of the collection request.
  always_comb begin
    free_vec   = '0;
    result_vec = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      free_vec[i]   = (slot_state[i] == SLOT_FREE);
      result_vec[i] = (slot_state[i] == SLOT_RESULT) &&
                      !(fb_valid && (fb_slot == PTR_W'(i)));
    end
  end

  assign dispatch_req = (state == ST_DISPATCH) ? free_vec : '0;
  assign fb_accept    = fb_valid && fb_ready;
  assign fb_load_ok   = !fb_valid || fb_ready;

  rr_arbiter #(.N(NUM_CORES), .PTR_W(PTR_W)) u_disp_arb (
    .req       (dispatch_req),
    .ptr       (disp_ptr),
    .grant     (disp_grant),
    .grant_idx (disp_idx),
    .any       (disp_any)
  );

  rr_arbiter #(.N(NUM_CORES), .PTR_W(PTR_W)) u_coll_arb (
    .req       (result_vec),
    .ptr       (coll_ptr),
    .grant     (coll_grant),
    .grant_idx (coll_idx),
    .any       (coll_any)
  );

  // One-hot mux of the selected result slot into the output register.
  always_comb begin
    coll_x     = '0;
    coll_y     = '0;
    coll_color = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (coll_grant[i]) begin
        coll_x     = coll_x | slot_x[i];
        coll_y     = coll_y | slot_y[i];
        coll_color = coll_color | slot_color[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      x_cnt       <= '0;
      y_cnt       <= '0;
      disp_ptr    <= '0;
      coll_ptr    <= '0;
      fb_slot     <= '0;
      core_strobe <= '0;
      core_x      <= '0;
      core_y      <= '0;
      fb_valid    <= 1'b0;
      fb_x        <= '0;
      fb_y        <= '0;
      fb_color    <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        slot_state[i] <= SLOT_FREE;
        slot_x[i]     <= '0;
        slot_y[i]     <= '0;
        slot_color[i] <= '0;
      end
    end else begin
      core_strobe <= disp_grant;
      frame_done  <= 1'b0;

      if (disp_any) begin
        core_x   <= x_cnt;
        core_y   <= y_cnt;
        disp_ptr <= (disp_idx == LAST_IDX) ? '0 : disp_idx + PTR_W'(1);
      end

      // Strobe, result capture and release act on disjoint slot states.
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        if (disp_grant[i]) begin
          slot_state[i] <= SLOT_BUSY;
          slot_x[i]     <= x_cnt;
          slot_y[i]     <= y_cnt;
        end else if (core_done[i] && (slot_state[i] == SLOT_BUSY)) begin
          slot_state[i] <= SLOT_RESULT;
          slot_color[i] <= core_color[i*COLOR_W +: COLOR_W];
        end else if (fb_accept && (fb_slot == PTR_W'(i))) begin
          slot_state[i] <= SLOT_FREE;
        end
      end

      if (fb_load_ok) begin
        if (coll_any) begin
          fb_valid <= 1'b1;
          fb_x     <= coll_x;
          fb_y     <= coll_y;
          fb_color <= coll_color;
          fb_slot  <= coll_idx;
          coll_ptr <= (coll_idx == LAST_IDX) ? '0 : coll_idx + PTR_W'(1);
        end else begin
          fb_valid <= 1'b0;
        end
      end

      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            state <= ST_DISPATCH;
            busy  <= 1'b1;
            x_cnt <= '0;
            y_cnt <= '0;
          end
        end
        ST_DISPATCH: begin
          if (disp_any) begin
            if (x_cnt == X_LAST) begin
              x_cnt <= '0;
              if (y_cnt == Y_LAST) state <= ST_DRAIN;
              else                 y_cnt <= y_cnt + COORD_W'(1);
            end else begin
              x_cnt <= x_cnt + COORD_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if ((&free_vec) && !fb_valid) begin
            state      <= ST_DONE;
            frame_done <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef RAY_DISPATCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if ((state == ST_IDLE) && frame_start) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if (busy) perf_cycles <= perf_cycles + 32'd1;
      if ((state == ST_DISPATCH) && !(|free_vec)) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ray_core_dispatcher.sv
// Scoreboard bench for ray_core_dispatcher on a 4x2 frame with 4 cores.
module tb_ray_core_dispatcher;

  localparam int NC = 4;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int CW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, frame_start, busy, frame_done;
  logic [NC-1:0]    core_strobe, core_done;
  logic [CW-1:0]    core_x, core_y, fb_x, fb_y;
  logic [NC*24-1:0] core_color;
  logic             fb_valid, fb_ready;
  logic [23:0]      fb_color;
`ifdef RAY_DISPATCH_PERF_EN
  logic [31:0]      perf_cycles, perf_stall;
`endif

  ray_core_dispatcher #(.NUM_CORES(NC), .SCREEN_W(W), .SCREEN_H(H), .COORD_W(CW)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .busy(busy),
    .frame_done(frame_done), .core_strobe(core_strobe), .core_x(core_x),
    .core_y(core_y), .core_done(core_done), .core_color(core_color),
    .fb_valid(fb_valid), .fb_ready(fb_ready), .fb_x(fb_x), .fb_y(fb_y),
    .fb_color(fb_color)
`ifdef RAY_DISPATCH_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] pix_color(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return {8'hA0 + y[7:0], 8'h50 + x[7:0], 8'h3C};
  endfunction

  typedef struct {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [23:0]   c;
  } exp_t;
  exp_t exp_q[$];

  // ---------------- ray core model: fixed 3-cycle latency or hold ----------
  int            cnt [NC];
  logic          pend[NC];
  logic [CW-1:0] lx  [NC];
  logic [CW-1:0] ly  [NC];
  bit            hold_mode   = 1'b0;
  bit            release_all = 1'b0;

  function automatic int pend_cnt();
    int n = 0;
    for (int i = 0; i < NC; i++) if (pend[i]) n++;
    return n;
  endfunction

  initial begin
    core_done  = '0;
    core_color = '0;
    for (int i = 0; i < NC; i++) begin
      cnt[i] = 0; pend[i] = 1'b0; lx[i] = '0; ly[i] = '0;
    end
    forever begin
      @(negedge clk); #1;
      core_done = '0;
      for (int i = 0; i < NC; i++) begin
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            core_done[i] = 1'b1;
            core_color[i*24 +: 24] = pix_color(lx[i], ly[i]);
          end
        end
        if (pend[i] && release_all) begin
          pend[i] = 1'b0;
          core_done[i] = 1'b1;
          core_color[i*24 +: 24] = pix_color(lx[i], ly[i]);
        end
        if (core_strobe[i]) begin
          lx[i] = core_x;
          ly[i] = core_y;
          if (hold_mode) pend[i] = 1'b1;
          else           cnt[i]  = 3;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int          cyc = 0, acc_tot = 0, strobes = 0, outst = 0;
  int          done_cnt = 0, fbv_cnt = 0;
  int          acc_cyc[$];
  logic        prev_hold = 1'b0;
  logic [43:0] prev_fb = '0;

  initial begin
    forever begin
      @(negedge clk); #2;
      cyc++;
      if (prev_hold) begin
        chk("fb_valid_held", fb_valid, 1);
        chk("fb_stable", {fb_x, fb_y, fb_color}, prev_fb);
      end
      prev_hold = fb_valid && !fb_ready;
      prev_fb   = {fb_x, fb_y, fb_color};
      if (fb_valid) fbv_cnt++;
      if (fb_valid && fb_ready) begin
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("fb_x", fb_x, e.x);
          chk("fb_y", fb_y, e.y);
          chk("fb_color", fb_color, e.c);
        end
        acc_tot++;
        outst--;
        acc_cyc.push_back(cyc);
      end
      if (|core_strobe) begin
        strobes++;
        outst++;
        chk("strobe_onehot", $onehot(core_strobe), 1);
        chk("outstanding_le_cores", outst <= NC, 1);
      end
      if (frame_done) done_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_frame(input bit push);
    @(negedge clk);
    chk("busy_before_start", busy, 0);
    frame_start = 1'b1;
    if (push)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          exp_q.push_back('{x: CW'(x), y: CW'(y), c: pix_color(CW'(x), CW'(y))});
    @(negedge clk);
    frame_start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) @(negedge clk);
    chk("frame_done_seen", done_cnt != d0, 1);
  endtask

  task automatic check_reset_values();
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_core_strobe", core_strobe, 0);
    chk("rst_fb_valid", fb_valid, 0);
    chk("rst_fb_x", fb_x, 0);
    chk("rst_fb_y", fb_y, 0);
    chk("rst_fb_color", fb_color, 0);
  endtask

  task automatic basic_frame();
    int d0, a0;
    d0 = done_cnt; a0 = acc_tot;
    start_frame(1'b1);
    wait_done(300);
    repeat (3) @(negedge clk);
    chk("basic_writes", acc_tot - a0, W*H);
    chk("basic_done_once", done_cnt - d0, 1);
    chk("basic_busy_low", busy, 0);
    chk("basic_sb_empty", exp_q.size(), 0);
  endtask

  // ---------------- optional perf instance: single core ----------------
`ifdef RAY_DISPATCH_PERF_EN
  logic          p_start = 1'b0, p_busy, p_done_pulse, p_strobe, p_done, p_fbv;
  logic [CW-1:0] p_cx, p_cy, p_fx, p_fy;
  logic [23:0]   p_color, p_fcol;
  logic [31:0]   p_cycles, p_stall;
  int            p_cnt = 0, p_busy_cyc = 0, p_done_cnt = 0, p_acc = 0;
  logic [CW-1:0] p_lx, p_ly;

  ray_core_dispatcher #(.NUM_CORES(1), .SCREEN_W(W), .SCREEN_H(H), .COORD_W(CW)) dut1 (
    .clk(clk), .reset(reset), .frame_start(p_start), .busy(p_busy),
    .frame_done(p_done_pulse), .core_strobe(p_strobe), .core_x(p_cx),
    .core_y(p_cy), .core_done(p_done), .core_color(p_color),
    .fb_valid(p_fbv), .fb_ready(1'b1), .fb_x(p_fx), .fb_y(p_fy),
    .fb_color(p_fcol), .perf_cycles(p_cycles), .perf_stall(p_stall)
  );

  initial begin
    p_done = 1'b0; p_color = '0; p_lx = '0; p_ly = '0;
    forever begin
      @(negedge clk); #1;
      p_done = 1'b0;
      if (p_cnt > 0) begin
        p_cnt--;
        if (p_cnt == 0) begin p_done = 1'b1; p_color = pix_color(p_lx, p_ly); end
      end
      if (p_strobe) begin p_lx = p_cx; p_ly = p_cy; p_cnt = 3; end
    end
  end

  initial begin
    forever begin
      @(negedge clk); #2;
      if (p_busy) p_busy_cyc++;
      if (p_done_pulse) p_done_cnt++;
      if (p_fbv) p_acc++;
    end
  end
`endif

  // ---------------- directed sequence ----------------
  initial begin
    int a0, s0, d0, f0, n, sz;
    reset = 1'b1; frame_start = 1'b0; fb_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values();
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // full-throughput frame, every pixel in raster order
    basic_frame();

    // framebuffer back-pressure for 20+ cycles
    fb_ready = 1'b0;
    a0 = acc_tot; s0 = strobes;
    start_frame(1'b1);
    repeat (25) @(negedge clk);
    chk("stall_strobes", strobes - s0, NC);
    chk("stall_no_accept", acc_tot - a0, 0);
    fb_ready = 1'b1;
    wait_done(300);
    repeat (3) @(negedge clk);
    chk("stall_writes", acc_tot - a0, W*H);
    chk("stall_sb_empty", exp_q.size(), 0);

    // all cores finishing in the same cycle, twice per frame
    hold_mode = 1'b1;
    a0 = acc_tot;
    start_frame(1'b1);
    for (int r = 0; r < 2; r++) begin
      for (n = 0; n < 60 && pend_cnt() != NC; n++) @(negedge clk);
      chk("hold_all_pending", pend_cnt(), NC);
      @(negedge clk); release_all = 1'b1;
      @(negedge clk); release_all = 1'b0;
      s0 = acc_tot;
      for (n = 0; n < 20 && (acc_tot - s0) < NC; n++) @(negedge clk);
      chk("burst_count", acc_tot - s0, NC);
      sz = acc_cyc.size();
      if (sz >= NC) chk("burst_back_to_back", acc_cyc[sz-1] - acc_cyc[sz-NC], NC-1);
    end
    wait_done(300);
    hold_mode = 1'b0;
    repeat (3) @(negedge clk);
    chk("burst_writes", acc_tot - a0, W*H);

    // frame_start while a frame is running is ignored
    a0 = acc_tot; d0 = done_cnt;
    start_frame(1'b1);
    repeat (2) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    wait_done(300);
    repeat (15) @(negedge clk);
    chk("ignore_writes", acc_tot - a0, W*H);
    chk("ignore_done_once", done_cnt - d0, 1);
    chk("ignore_busy_low", busy, 0);
    chk("ignore_sb_empty", exp_q.size(), 0);

    // reset in the middle of a frame, stale core_done afterwards
    start_frame(1'b1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    exp_q.delete();
    check_reset_values();
    @(negedge clk);
    reset = 1'b0;
    #3;
    outst = 0;
    f0 = fbv_cnt; s0 = strobes;
    repeat (12) @(negedge clk);
    chk("stale_no_fb_valid", fbv_cnt - f0, 0);
    chk("stale_no_strobe", strobes - s0, 0);
    chk("stale_busy_low", busy, 0);
    chk("stale_fb_x", fb_x, 0);
    chk("stale_fb_color", fb_color, 0);

    // clean frame after the abandoned one
    basic_frame();

`ifdef RAY_DISPATCH_PERF_EN
    @(negedge clk); p_start = 1'b1;
    @(negedge clk); p_start = 1'b0;
    for (n = 0; n < 400 && p_done_cnt == 0; n++) @(negedge clk);
    chk("perf_frame_done", p_done_cnt, 1);
    repeat (5) @(negedge clk);
    chk("perf_writes", p_acc, W*H);
    chk("perf_busy_duration", p_busy_cyc, 58);
    chk("perf_cycles_eq_busy", p_cycles, p_busy_cyc);
    chk("perf_stall_nonzero", p_stall != 0, 1);
    chk("perf_stall", p_stall, 42);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
